seq_mul_div: RTL and testbench

- Multi-cycle multiply/divide sequencer for the stack-processor ALU path.
- Takes TOP and NEXT as operands on a start request and runs one shift-add (multiply) or restore-subtract (divide) step per clock for DATA_WIDTH steps.
- Returns the 2*DATA_WIDTH-bit result as hi/lo words, which feed the MD/SR accumulator inputs.
- Holds halt_pc high while running so the program counter stalls, the same way the I/O halt does.

---
 rtl/seq_mul_div.sv | 155 +++++++++++++++
 tb/tb_seq_mul_div.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_div.sv
// Multi-cycle unsigned multiply/divide sequencer for the stack-processor ALU path.
// One shift-add or restoring-subtract step per clock; halt_pc stalls the PC while running.
module seq_mul_div #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  read_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  busy,
  output logic                  done,
  output logic                  halt_pc,
  output logic                  div_zero
);

  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [W-1:0]         acc_hi_q, acc_hi_d;
  logic [W-1:0]         acc_lo_q, acc_lo_d;
  logic [W-1:0]         oper_q, oper_d;
  logic                 op_q, op_d;
  logic [W-1:0]         res_hi_q, res_hi_d;
  logic [W-1:0]         res_lo_q, res_lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;
  logic                 accept;

  logic [W:0]   mul_sum;
  logic [W:0]   rem_shift;
  logic [W:0]   trial;
  logic [W-1:0] step_hi, step_lo;

  // One datapath step: mul keeps multiplier in acc_lo, div keeps {remainder, quotient} in {acc_hi, acc_lo}.
  // The W+1-bit trial difference always fits, so its MSB is a valid sign bit.
  always_comb begin : step
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, oper_q} : '0);
    rem_shift = {acc_hi_q, acc_lo_q[W-1]};
    trial     = rem_shift - {1'b0, oper_q};
    if (op_q) begin
      if (!trial[W]) begin
        step_hi = trial[W-1:0];
        step_lo = {acc_lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = rem_shift[W-1:0];
        step_lo = {acc_lo_q[W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo_q[W-1:1]};
    end
  end

  always_comb begin : fsm
    state_d   = state_q;
    counter_d = counter_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    oper_d    = oper_q;
    op_d      = op_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dz_d      = dz_q;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: accept = start;
      S_RUN: begin
        busy_d    = 1'b1;
        counter_d = counter_q + CNT_WIDTH'(1);
        acc_hi_d  = step_hi;
        acc_lo_d  = step_lo;
        if (counter_q == CNT_WIDTH'(W - 1)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          res_hi_d = step_hi;
          res_lo_d = step_lo;
        end
      end
      S_DONE: begin
        accept = start;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // New operation from IDLE or back-to-back from DONE; divide by zero skips RUN.
    if (accept) begin
      op_d = op;
      dz_d = 1'b0;
      if (op && (operand_b == '0)) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        dz_d     = 1'b1;
        res_lo_d = '1;
        res_hi_d = operand_a;
      end else begin
        state_d   = S_RUN;
        busy_d    = 1'b1;
        counter_d = '0;
        acc_hi_d  = '0;
        acc_lo_d  = op ? operand_a : operand_b;
        oper_d    = op ? operand_b : operand_a;
      end
    end
  end

  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      oper_q    <= '0;
      op_q      <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      oper_q    <= oper_d;
      op_q      <= op_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;
  assign busy      = busy_q;
  assign halt_pc   = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: arithmetic reference model compared every cycle,
// directed literal cases, and randomized back-to-back/idle traffic.
module tb_seq_mul_div;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result_lo, result_hi;
  logic         busy, done, halt_pc, div_zero;

  int errors = 0;
  int checks = 0;

  seq_mul_div #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
    .read_clock(clk),
    .reset     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (a),
    .operand_b (b),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .busy      (busy),
    .done      (done),
    .halt_pc   (halt_pc),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference model: outputs derived from a countdown and plain * / % arithmetic.
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_hi, m_lo, pend_hi, pend_lo;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_hi <= pend_hi; m_lo <= pend_lo;
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_dz <= 1'b0;
        if (op && b == '0) begin
          m_done <= 1'b1; m_dz <= 1'b1;
          m_lo <= 16'hFFFF; m_hi <= a;
        end else begin
          m_busy <= 1'b1; m_left <= W;
          if (op) begin
            pend_lo <= a / b;
            pend_hi <= a % b;
          end else begin
            {pend_hi, pend_lo} <= {16'h0, a} * {16'h0, b};
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("busy",      32'(busy),      32'(m_busy));
    chk("halt_pc",   32'(halt_pc),   32'(m_busy));
    chk("done",      32'(done),      32'(m_done));
    chk("result_hi", 32'(result_hi), 32'(m_hi));
    chk("result_lo", 32'(result_lo), 32'(m_lo));
    chk("div_zero",  32'(div_zero),  32'(m_dz));
  endtask

  // Called at a falling edge; operands are scrambled after the start edge.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  // n = rising edges after the start edge up to the one that raised done.
  task automatic wait_done(output int n, input bit noise);
    n = 0;
    while (!done && n < 40) begin
      if (noise) begin
        start = 1'($urandom); op = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (n >= 40) chk("done_timeout", 32'(n), 32'(W));
  endtask

  int n;

  initial begin
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lo",   32'(result_lo), 32'h0);
    rst_n = 1'b1;
    tick();

    // Done occupies cycle N+17: 16 edges after the start edge.
    do_op(1'b0, 16'h1234, 16'h0010);
    chk("mul1_busy", 32'(busy), 32'h1);
    wait_done(n, 1'b0);
    chk("mul1_lat", 32'(n), 32'd16);
    chk("mul1_hi", 32'(result_hi), 32'h0001);
    chk("mul1_lo", 32'(result_lo), 32'h2340);
    chk("mul1_dz", 32'(div_zero), 32'h0);
    tick();

    do_op(1'b0, 16'hFFFF, 16'hFFFF);
    wait_done(n, 1'b0);
    chk("mulmax_hi", 32'(result_hi), 32'hFFFE);
    chk("mulmax_lo", 32'(result_lo), 32'h0001);
    do_op(1'b0, 16'h0000, 16'h1234);
    chk("b2b_busy", 32'(busy), 32'h1);
    wait_done(n, 1'b0);
    chk("b2b_lat", 32'(n), 32'd16);
    chk("mul0_hi", 32'(result_hi), 32'h0);
    chk("mul0_lo", 32'(result_lo), 32'h0);
    tick();

    do_op(1'b1, 16'h03E8, 16'h0007);
    wait_done(n, 1'b0);
    chk("div1_lat", 32'(n), 32'd16);
    chk("div1_lo", 32'(result_lo), 32'h008E);
    chk("div1_hi", 32'(result_hi), 32'h0006);
    do_op(1'b1, 16'h0005, 16'h0009);
    wait_done(n, 1'b0);
    chk("div2_lo", 32'(result_lo), 32'h0000);
    chk("div2_hi", 32'(result_hi), 32'h0005);
    tick();

    do_op(1'b1, 16'h00AB, 16'h0000);
    wait_done(n, 1'b0);
    chk("dz_lat", 32'(n), 32'd0);
    chk("dz_busy", 32'(busy), 32'h0);
    chk("dz_lo", 32'(result_lo), 32'hFFFF);
    chk("dz_hi", 32'(result_hi), 32'h00AB);
    chk("dz_flag", 32'(div_zero), 32'h1);
    tick();
    do_op(1'b0, 16'h0002, 16'h0002);
    chk("dz_clear", 32'(div_zero), 32'h0);
    wait_done(n, 1'b0);

    do_op(1'b0, 16'h0003, 16'h0005);
    wait_done(n, 1'b1);
    chk("ign_lat", 32'(n), 32'd16);
    chk("ign_hi", 32'(result_hi), 32'h0000);
    chk("ign_lo", 32'(result_lo), 32'h000F);
    tick();

    // Asynchronous reset in the middle of RUN.
    do_op(1'b0, 16'h1234, 16'h0010);
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_halt", 32'(halt_pc), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_hi", 32'(result_hi), 32'h0);
    chk("arst_lo", 32'(result_lo), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_op(1'b0, 16'h0002, 16'h0003);
    wait_done(n, 1'b0);
    chk("post_lat", 32'(n), 32'd16);
    chk("post_lo", 32'(result_lo), 32'h0006);
    chk("post_hi", 32'(result_hi), 32'h0000);

    // Randomized traffic with back-to-back starts and idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic          ro;
      logic [W-1:0]  ra, rb;
      ro = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      do_op(ro, ra, rb);
      wait_done(n, 1'($urandom));
      chk("rnd_lat", 32'(n), (ro && rb == '0) ? 32'd0 : 32'd16);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
